// File: rtl/ex_mem_wb_backend.sv
// ex_mem_wb_backend
//   Back half of the 16-bit five-stage MIPS pipeline. It holds the EX ALU, the
//   EX/MEM register, the data memory, the MEM/WB register and the writeback mux.
//   It consumes the ID/EX register outputs and returns branch resolution to
//   fetch and the register-file write port to decode.
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   in_PC_plus_two         PC+2 of the instruction in EX
//   in_Read_data_1/2       rs operand, rt operand (also the store data)
//   in_immediate           sign-extended immediate; [2:0] is the R-type funct
//   in_ALU_Src, in_ALUOp   ALU B select and operation class
//   in_RegDest, in_rt/rd   destination select and register specifiers
//   in_MemRead .. in_RegWrite  control bits from ID/EX
//   PC_Src, branch_target  taken branch and its target (to fetch)
//   flush                  same as PC_Src; upstream squashes IF/ID and ID/EX
//   RegWrite_out, write_register, write_Data  register-file write port
module ex_mem_wb_backend #(
   parameter int DMEM_DEPTH = 256,
   parameter int DMEM_AW    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_PC_plus_two,
   input  logic [15:0] in_Read_data_1,
   input  logic [15:0] in_Read_data_2,
   input  logic [15:0] in_immediate,
   input  logic        in_ALU_Src,
   input  logic [1:0]  in_ALUOp,
   input  logic        in_RegDest,
   input  logic [2:0]  in_rt,
   input  logic [2:0]  in_rd,
   input  logic        in_MemRead,
   input  logic        in_MemWrite,
   input  logic        in_Branch,
   input  logic        in_MemtoReg,
   input  logic        in_RegWrite,
   output logic        PC_Src,
   output logic [15:0] branch_target,
   output logic        flush,
   output logic        RegWrite_out,
   output logic [2:0]  write_register,
   output logic [15:0] write_Data
);

   // EX stage
   logic [15:0] alu_b;
   logic [15:0] alu_result;
   logic [15:0] target;
   logic [2:0]  dest;
   logic        zero_e;

   always_comb begin
      alu_b      = in_ALU_Src ? in_immediate : in_Read_data_2;
      alu_result = in_Read_data_1 + alu_b;
      case (in_ALUOp)
         2'b01: alu_result = in_Read_data_1 - alu_b;
         2'b10: begin
            case (in_immediate[2:0])
               3'b001:  alu_result = in_Read_data_1 - alu_b;
               3'b010:  alu_result = in_Read_data_1 & alu_b;
               3'b011:  alu_result = in_Read_data_1 | alu_b;
               3'b100:  alu_result = {15'd0, ($signed(in_Read_data_1) < $signed(alu_b))};
               default: alu_result = in_Read_data_1 + alu_b;
            endcase
         end
         default: alu_result = in_Read_data_1 + alu_b;
      endcase
   end

   assign zero_e = (alu_result == '0);
   assign target = in_PC_plus_two + {in_immediate[14:0], 1'b0};
   assign dest   = in_RegDest ? in_rd : in_rt;

   // EX/MEM register
   logic [15:0] alu_m;
   logic [15:0] store_m;
   logic [15:0] target_m;
   logic [2:0]  dest_m;
   logic        zero_m;
   logic        MemRead_m;
   logic        MemWrite_m;
   logic        Branch_m;
   logic        MemtoReg_m;
   logic        RegWrite_m;
   logic        pc_src;

   assign pc_src = Branch_m & zero_m;

   // While a taken branch sits in MEM, the instruction in EX is on the wrong
   // path: it still flows down but with every side-effecting control cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_m      <= '0;
         store_m    <= '0;
         target_m   <= '0;
         dest_m     <= '0;
         zero_m     <= 1'b0;
         MemRead_m  <= 1'b0;
         MemWrite_m <= 1'b0;
         Branch_m   <= 1'b0;
         MemtoReg_m <= 1'b0;
         RegWrite_m <= 1'b0;
      end else begin
         alu_m      <= alu_result;
         store_m    <= in_Read_data_2;
         target_m   <= target;
         dest_m     <= dest;
         zero_m     <= zero_e;
         MemtoReg_m <= in_MemtoReg;
         MemRead_m  <= in_MemRead  & ~pc_src;
         MemWrite_m <= in_MemWrite & ~pc_src;
         Branch_m   <= in_Branch   & ~pc_src;
         RegWrite_m <= in_RegWrite & ~pc_src;
      end
   end

   // MEM stage: byte address -> word index, upper address bits wrap.
   logic [15:0]        mem [DMEM_DEPTH] = '{default: '0};
   logic [DMEM_AW-1:0] mem_idx;
   logic [15:0]        load_data;

   assign mem_idx   = alu_m[DMEM_AW:1];
   assign load_data = MemRead_m ? mem[mem_idx] : '0;

   always_ff @(posedge clk) begin
      if (!rst && MemWrite_m) begin
         mem[mem_idx] <= store_m;
      end
   end

   // MEM/WB register
   logic [15:0] load_w;
   logic [15:0] alu_w;
   logic [2:0]  dest_w;
   logic        MemtoReg_w;
   logic        RegWrite_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         load_w     <= '0;
         alu_w      <= '0;
         dest_w     <= '0;
         MemtoReg_w <= 1'b0;
         RegWrite_w <= 1'b0;
      end else begin
         load_w     <= load_data;
         alu_w      <= alu_m;
         dest_w     <= dest_m;
         MemtoReg_w <= MemtoReg_m;
         RegWrite_w <= RegWrite_m;
      end
   end

   // Outputs
   assign PC_Src         = pc_src;
   assign flush          = pc_src;
   assign branch_target  = target_m;
   assign RegWrite_out   = RegWrite_w;
   assign write_register = dest_w;
   assign write_Data     = MemtoReg_w ? load_w : alu_w;

endmodule

// File: tb/tb_ex_mem_wb_backend.sv
// tb_ex_mem_wb_backend
//   Drives a program of one instruction per cycle (directed scenarios followed
//   by random ones, with occasional resets) and checks every output against a
//   program-order reference model of the back end.
module tb_ex_mem_wb_backend;

   localparam int NCYC       = 400;
   localparam int DMEM_DEPTH = 256;

   typedef struct {
      logic [15:0] pc2, rd1, rd2, imm;
      logic        src;
      logic [1:0]  op;
      logic        rdst;
      logic [2:0]  rt, rd;
      logic        mr, mw, br, m2r, rw;
      logic        rst;
   } ins_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_PC_plus_two, in_Read_data_1, in_Read_data_2, in_immediate;
   logic        in_ALU_Src;
   logic [1:0]  in_ALUOp;
   logic        in_RegDest;
   logic [2:0]  in_rt, in_rd;
   logic        in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite;
   logic        PC_Src, flush, RegWrite_out;
   logic [15:0] branch_target, write_Data;
   logic [2:0]  write_register;

   ex_mem_wb_backend #(.DMEM_DEPTH(DMEM_DEPTH), .DMEM_AW(8)) dut (
      .clk(clk), .rst(rst),
      .in_PC_plus_two(in_PC_plus_two), .in_Read_data_1(in_Read_data_1),
      .in_Read_data_2(in_Read_data_2), .in_immediate(in_immediate),
      .in_ALU_Src(in_ALU_Src), .in_ALUOp(in_ALUOp), .in_RegDest(in_RegDest),
      .in_rt(in_rt), .in_rd(in_rd),
      .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite), .in_Branch(in_Branch),
      .in_MemtoReg(in_MemtoReg), .in_RegWrite(in_RegWrite),
      .PC_Src(PC_Src), .branch_target(branch_target), .flush(flush),
      .RegWrite_out(RegWrite_out), .write_register(write_register),
      .write_Data(write_Data)
   );

   always #5 clk = ~clk;

   ins_t        prog [NCYC];
   logic        e_pc   [NCYC];
   logic [15:0] e_tgt  [NCYC];
   logic        e_rw   [NCYC];
   logic [2:0]  e_wr   [NCYC];
   logic [15:0] e_wd   [NCYC];
   logic        e_full [NCYC];  // write port fully defined (after reset or real write)
   logic        taken  [NCYC];
   logic [15:0] mmem   [DMEM_DEPTH];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic ins_t nop();
      ins_t i;
      i = '{pc2: 16'h0, rd1: 16'h0, rd2: 16'h0, imm: 16'h0, src: 1'b0, op: 2'b00,
            rdst: 1'b0, rt: 3'd0, rd: 3'd0, mr: 1'b0, mw: 1'b0, br: 1'b0,
            m2r: 1'b0, rw: 1'b0, rst: 1'b0};
      return i;
   endfunction

   function automatic ins_t alu_ins(input logic [1:0] op, input logic [15:0] a,
                                    input logic [15:0] b, input logic [15:0] imm,
                                    input logic [2:0] rd);
      ins_t i;
      i = nop();
      i.op = op; i.rd1 = a; i.rd2 = b; i.imm = imm; i.rdst = 1'b1; i.rd = rd; i.rw = 1'b1;
      return i;
   endfunction

   function automatic ins_t mem_ins(input logic is_store, input logic [15:0] base,
                                    input logic [15:0] imm, input logic [15:0] data,
                                    input logic [2:0] rt);
      ins_t i;
      i = nop();
      i.src = 1'b1; i.rd1 = base; i.imm = imm; i.rd2 = data; i.rt = rt;
      if (is_store) i.mw = 1'b1;
      else begin i.mr = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; end
      return i;
   endfunction

   function automatic ins_t beq_ins(input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] pc2, input logic [15:0] imm);
      ins_t i;
      i = nop();
      i.op = 2'b01; i.rd1 = a; i.rd2 = b; i.pc2 = pc2; i.imm = imm; i.br = 1'b1;
      return i;
   endfunction

   function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [2:0] fn,
                                           input logic [15:0] a, input logic [15:0] b);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (op == 2'b01 || (op == 2'b10 && fn == 3'd1)) return a - b;
      if (op == 2'b10 && fn == 3'd2) return a & b;
      if (op == 2'b10 && fn == 3'd3) return a | b;
      if (op == 2'b10 && fn == 3'd4) return (sa < sb) ? 16'd1 : 16'd0;
      return a + b;
   endfunction

   function automatic ins_t rand_ins();
      ins_t i;
      int   kind;
      i = nop();
      kind = $urandom_range(0, 4);
      i.pc2 = 16'($urandom); i.rt = 3'($urandom); i.rd = 3'($urandom);
      case (kind)
         0: begin
            i = alu_ins(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom_range(0, 7)), 3'($urandom));
            i.src = 1'($urandom);
         end
         1: i = mem_ins(1'b1, 16'($urandom) & 16'h021E, 16'($urandom_range(0, 3)) << 1, 16'($urandom), 3'($urandom));
         2: i = mem_ins(1'b0, 16'($urandom) & 16'h021E, 16'($urandom_range(0, 3)) << 1, 16'h0, 3'($urandom));
         3: begin
            i = beq_ins(16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) i.rw = 1'b1;
         end
         default: begin
            i.rd1 = 16'($urandom); i.rd2 = 16'($urandom); i.imm = 16'($urandom);
            i.src = 1'($urandom); i.op = 2'($urandom); i.rdst = 1'($urandom);
            i.mr = 1'($urandom); i.mw = 1'($urandom); i.br = 1'($urandom);
            i.m2r = 1'($urandom); i.rw = 1'($urandom);
            i.rd1 = i.rd1 & 16'h03FF;
         end
      endcase
      i.rst = ($urandom_range(0, 49) == 0);
      return i;
   endfunction

   // Walk the program in order: each instruction resolves its branch in the
   // cycle after issue, touches memory then, and writes back one cycle later.
   task automatic build_model();
      ins_t        i;
      logic [15:0] b, a, tgt, ld;
      logic        sq, dead, nxt_rst;
      int          idx;
      for (int k = 0; k < DMEM_DEPTH; k++) mmem[k] = 16'h0;
      for (int c = 0; c < NCYC; c++) begin
         i       = prog[c];
         b       = i.src ? i.imm : i.rd2;
         a       = alu_ref(i.op, i.imm[2:0], i.rd1, b);
         tgt     = i.pc2 + (i.imm << 1);
         sq      = (c > 0) && taken[c-1];
         taken[c] = !i.rst && !sq && i.br && (a == 16'h0);
         nxt_rst = (c + 1 < NCYC) ? prog[c+1].rst : 1'b0;
         dead    = i.rst || nxt_rst;
         idx     = (int'(a) / 2) % DMEM_DEPTH;
         ld      = (i.mr && !sq) ? mmem[idx] : 16'h0;
         if (!dead && i.mw && !sq) mmem[idx] = i.rd2;
         if (c + 1 < NCYC) begin
            e_pc[c+1]  = taken[c];
            e_tgt[c+1] = i.rst ? 16'h0 : tgt;
         end
         if (c + 2 < NCYC) begin
            if (dead) begin
               e_rw[c+2] = 1'b0; e_wr[c+2] = 3'd0; e_wd[c+2] = 16'h0; e_full[c+2] = 1'b1;
            end else begin
               e_rw[c+2]   = i.rw && !sq;
               e_wr[c+2]   = i.rdst ? i.rd : i.rt;
               e_wd[c+2]   = i.m2r ? ld : a;
               e_full[c+2] = i.rw && !sq;
            end
         end
      end
   endtask

   task automatic drive(input ins_t i);
      rst            = i.rst;
      in_PC_plus_two = i.pc2;
      in_Read_data_1 = i.rd1;
      in_Read_data_2 = i.rd2;
      in_immediate   = i.imm;
      in_ALU_Src     = i.src;
      in_ALUOp       = i.op;
      in_RegDest     = i.rdst;
      in_rt          = i.rt;
      in_rd          = i.rd;
      in_MemRead     = i.mr;
      in_MemWrite    = i.mw;
      in_Branch      = i.br;
      in_MemtoReg    = i.m2r;
      in_RegWrite    = i.rw;
   endtask

   initial begin
      ins_t t;
      prog[0] = nop(); prog[0].rst = 1'b1;
      prog[1] = nop(); prog[1].rst = 1'b1;
      prog[2]  = alu_ins(2'b10, 16'h0005, 16'h0003, 16'h0000, 3'd3);          // add -> 8
      prog[3]  = mem_ins(1'b1, 16'h0010, 16'h0004, 16'hBEEF, 3'd0);           // sw
      prog[4]  = mem_ins(1'b0, 16'h0010, 16'h0004, 16'h0000, 3'd2);           // lw behind sw
      prog[5]  = beq_ins(16'h0007, 16'h0007, 16'h0020, 16'h0003);             // taken -> 0x26
      prog[6]  = alu_ins(2'b00, 16'h1234, 16'h1111, 16'h0000, 3'd5);          // squashed
      prog[7]  = alu_ins(2'b00, 16'h7FFF, 16'h0001, 16'h0000, 3'd1);          // -> 0x8000
      prog[8]  = alu_ins(2'b10, 16'h8000, 16'h0001, 16'h0004, 3'd2);          // slt -> 1
      prog[9]  = beq_ins(16'h0001, 16'h0002, 16'h0040, 16'h0005);             // not taken
      prog[10] = mem_ins(1'b1, 16'h0010, 16'h0004, 16'hDEAD, 3'd0);           // sw killed by reset
      prog[11] = nop(); prog[11].rst = 1'b1;
      prog[12] = nop();
      prog[13] = mem_ins(1'b0, 16'h0010, 16'h0004, 16'h0000, 3'd4);           // still 0xBEEF
      prog[14] = mem_ins(1'b1, 16'h0200, 16'h0000, 16'h5A5A, 3'd0);           // wraps to word 0
      prog[15] = nop();
      prog[16] = mem_ins(1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd6);           // 0x5A5A
      for (int c = 17; c < NCYC; c++) prog[c] = rand_ins();

      build_model();

      for (int c = 0; c < NCYC; c++) begin
         cyc = c;
         t = prog[c];
         drive(t);
         #4;
         if (c >= 2) begin
            check("pc_src", {15'd0, PC_Src}, {15'd0, e_pc[c]});
            check("flush", {15'd0, flush}, {15'd0, e_pc[c]});
            check("branch_target", branch_target, e_tgt[c]);
            check("regwrite", {15'd0, RegWrite_out}, {15'd0, e_rw[c]});
            if (e_full[c]) begin
               check("write_register", {13'd0, write_register}, {13'd0, e_wr[c]});
               check("write_data", write_Data, e_wd[c]);
            end
         end
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
